// File: rtl/multicycle_controller_unit_if.sv
// multicycle_controller_unit_if: controller <-> datapath signal bundle
// master: controller side (drives control outputs, reads op/funct/zero/mem_ready)
// slave:  datapath side (drives op/funct/zero/mem_ready, reads control outputs)
interface multicycle_controller_unit_if;
    logic [5:0] op;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, funct, zero, mem_ready,
        output pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, instr_done, illegal, state
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_controller_unit.sv
// multicycle_controller_unit: control FSM sequencing the multicycle MIPS datapath
// Ports: clk, rst (async, active-high); bus (master modport) carries op/funct/zero/
// mem_ready in and the memory, IR, PC, ALU-source and writeback controls out.
module multicycle_controller_unit #(
    parameter bit ENABLE_BNE   = 1'b1,
    parameter bit ENABLE_STALL = 1'b1
) (
    input logic                          clk,
    input logic                          rst,
    multicycle_controller_unit_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_d;
    logic       rdy, fn_ok;
    logic [2:0] fn_alu;
    logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    assign rdy = ENABLE_STALL ? bus.mem_ready : 1'b1;

    assign fn_ok  = bus.funct inside {4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010};
    assign fn_alu = bus.funct == 4'b0010 ? 3'b110 :
                    bus.funct == 4'b0100 ? 3'b000 :
                    bus.funct == 4'b0101 ? 3'b001 :
                    bus.funct == 4'b1010 ? 3'b111 : 3'b010;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite    = rdy;
                pc_en      = rdy;
                state_d    = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                state_d    = (bus.op == OP_LW || bus.op == OP_SW)               ? MEMADR :
                             bus.op == OP_R                                     ? EXEC   :
                             (bus.op == OP_BEQ || (ENABLE_BNE && bus.op == OP_BNE)) ? BRANCH :
                             bus.op == OP_ADDI                                  ? ADDIEX :
                             bus.op == OP_J                                     ? JUMP   : FETCH;
                illegal    = state_d == FETCH;
                instr_done = state_d == FETCH;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                state_d    = bus.op == OP_SW ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = fn_alu;
                illegal    = !fn_ok;
                instr_done = !fn_ok;
                state_d    = fn_ok ? ALUWB : FETCH;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                // op[0] distinguishes bne from beq; bne only reaches here when enabled
                pc_en      = bus.op[0] ? !bus.zero : bus.zero;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset is asynchronous, so enables are masked combinationally to stop any
    // write the moment rst rises rather than at the next edge.
    assign bus.pc_en      = pc_en & ~rst;
    assign bus.irwrite    = irwrite & ~rst;
    assign bus.regwrite   = regwrite & ~rst;
    assign bus.memwrite   = memwrite & ~rst;
    assign bus.instr_done = instr_done & ~rst;
    assign bus.illegal    = illegal & ~rst;
    assign bus.iord       = iord;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.alucontrol = alucontrol;
    assign bus.pcsrc      = pcsrc;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_controller_unit.sv
module tb_multicycle_controller_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b0;
    logic [3:0] funct = 4'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    int         checks = 0;
    int         errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

    multicycle_controller_unit_if b0 ();
    multicycle_controller_unit_if b1 ();
    multicycle_controller_unit_if b2 ();

    assign b0.op = op;  assign b0.funct = funct;  assign b0.zero = zero;  assign b0.mem_ready = mem_ready;
    assign b1.op = op;  assign b1.funct = funct;  assign b1.zero = zero;  assign b1.mem_ready = mem_ready;
    assign b2.op = op;  assign b2.funct = funct;  assign b2.zero = zero;  assign b2.mem_ready = mem_ready;

    multicycle_controller_unit dut (.clk(clk), .rst(rst), .bus(b0));
    multicycle_controller_unit #(.ENABLE_BNE(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(b1));
    multicycle_controller_unit #(.ENABLE_STALL(1'b0)) dut_ns (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; op = LW;
        @(negedge clk);
        checks++; if (b0.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", b0.state); end
        checks++; if ({b0.pc_en, b0.irwrite, b0.regwrite, b0.memwrite, b0.instr_done, b0.illegal} !== 6'b0) begin
            errors++; $display("FAIL reset_enables got %b exp 000000", {b0.pc_en, b0.irwrite, b0.regwrite, b0.memwrite, b0.instr_done, b0.illegal}); end
        checks++; if ({b0.iord, b0.alusrca, b0.alusrcb, b0.alucontrol} !== 7'b0001010) begin
            errors++; $display("FAIL reset_muxes got %b exp 0001010", {b0.iord, b0.alusrca, b0.alusrcb, b0.alucontrol}); end
        nxt();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (b0.state !== 4'd0 || b0.irwrite !== 1'b1 || b0.pc_en !== 1'b1) begin
            errors++; $display("FAIL first_fetch got state %0d irwrite %b pc_en %b exp 0 1 1", b0.state, b0.irwrite, b0.pc_en); end
    endtask

    task automatic test_fetch_stall();
        do_reset(); op = JMP; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (b0.state !== 4'd0 || b0.irwrite !== 1'b0 || b0.pc_en !== 1'b0) begin
                errors++; $display("FAIL fetch_stall cyc %0d got state %0d irwrite %b pc_en %b exp 0 0 0", k, b0.state, b0.irwrite, b0.pc_en); end
            nxt();
        end
        mem_ready = 1'b1;
        nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd1) begin errors++; $display("FAIL fetch_resume got %0d exp 1", b0.state); end
    endtask

    task automatic test_reset_mid_memwr();
        do_reset(); op = SW; mem_ready = 1'b1;
        nxt(); nxt(); nxt();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (b0.state !== 4'd5 || b0.memwrite !== 1'b1) begin
            errors++; $display("FAIL memwr_reach got state %0d memwrite %b exp 5 1", b0.state, b0.memwrite); end
        rst = 1'b1;
        #1;
        checks++; if (b0.state !== 4'd0 || b0.memwrite !== 1'b0 || b0.instr_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_memwr got state %0d memwrite %b done %b exp 0 0 0", b0.state, b0.memwrite, b0.instr_done); end
        nxt();
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (b0.state !== 4'd0 || b0.irwrite !== 1'b1) begin
            errors++; $display("FAIL refetch got state %0d irwrite %b exp 0 1", b0.state, b0.irwrite); end
    endtask

    task automatic test_lw();
        do_reset(); op = LW; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (b0.state !== 4'(k)) begin errors++; $display("FAIL lw_state cyc %0d got %0d exp %0d", k, b0.state, k); end
            checks++; if ({b0.regwrite, b0.memtoreg, b0.instr_done} !== ((k == 4) ? 3'b111 : 3'b000)) begin
                errors++; $display("FAIL lw_wb cyc %0d got %b exp %b", k, {b0.regwrite, b0.memtoreg, b0.instr_done}, (k == 4) ? 3'b111 : 3'b000); end
            checks++; if (b0.iord !== (k == 3)) begin errors++; $display("FAIL lw_iord cyc %0d got %b exp %b", k, b0.iord, k == 3); end
            if (k == 2) begin
                checks++; if ({b0.alusrca, b0.alusrcb, b0.alucontrol} !== 6'b110010) begin
                    errors++; $display("FAIL lw_memadr got %b exp 110010", {b0.alusrca, b0.alusrcb, b0.alucontrol}); end
            end
            if (k == 1) begin
                checks++; if ({b0.alusrca, b0.alusrcb, b0.alucontrol} !== 6'b011010) begin
                    errors++; $display("FAIL decode_mux got %b exp 011010", {b0.alusrca, b0.alusrcb, b0.alucontrol}); end
            end
            nxt();
        end
        @(negedge clk);
        checks++; if (b0.state !== 4'd0) begin errors++; $display("FAIL lw_end got %0d exp 0", b0.state); end
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp_st;
        do_reset(); op = SW;
        for (int k = 0; k < 7; k++) begin
            mem_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            exp_st = (k < 3) ? 4'(k) : 4'd5;
            @(negedge clk);
            checks++; if (b0.state !== exp_st) begin errors++; $display("FAIL sw_state cyc %0d got %0d exp %0d", k, b0.state, exp_st); end
            checks++; if (b0.memwrite !== (k >= 3) || b0.instr_done !== (k == 6)) begin
                errors++; $display("FAIL sw_ctrl cyc %0d got memwrite %b done %b exp %b %b", k, b0.memwrite, b0.instr_done, k >= 3, k == 6); end
            nxt();
        end
        @(negedge clk);
        checks++; if (b0.state !== 4'd0) begin errors++; $display("FAIL sw_end got %0d exp 0", b0.state); end
    endtask

    task automatic test_rtype();
        logic [3:0] fn [6] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1111};
        logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        for (int i = 0; i < 6; i++) begin
            do_reset(); op = RT; funct = fn[i]; mem_ready = 1'b1;
            nxt(); nxt();
            @(negedge clk);
            checks++; if (b0.state !== 4'd6 || b0.alucontrol !== ac[i] || {b0.alusrca, b0.alusrcb} !== 3'b100) begin
                errors++; $display("FAIL exec funct %b got state %0d alu %b srcs %b exp 6 %b 100", fn[i], b0.state, b0.alucontrol, {b0.alusrca, b0.alusrcb}, ac[i]); end
            checks++; if (b0.illegal !== (i == 5) || b0.instr_done !== (i == 5) || b0.regwrite !== 1'b0) begin
                errors++; $display("FAIL exec_flags funct %b got ill %b done %b rw %b exp %b %b 0", fn[i], b0.illegal, b0.instr_done, b0.regwrite, i == 5, i == 5); end
            nxt();
            @(negedge clk);
            if (i == 5) begin
                checks++; if (b0.state !== 4'd0 || b0.regwrite !== 1'b0) begin
                    errors++; $display("FAIL rt_illegal_end got state %0d rw %b exp 0 0", b0.state, b0.regwrite); end
            end else begin
                checks++; if (b0.state !== 4'd7 || {b0.regdst, b0.memtoreg, b0.regwrite, b0.instr_done} !== 4'b1011) begin
                    errors++; $display("FAIL aluwb funct %b got state %0d ctl %b exp 7 1011", fn[i], b0.state, {b0.regdst, b0.memtoreg, b0.regwrite, b0.instr_done}); end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] bo [4] = '{BEQ, BEQ, BNE, BNE};
        logic       bz [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_reset(); op = bo[i]; zero = bz[i]; mem_ready = 1'b1;
            nxt(); nxt();
            @(negedge clk);
            checks++; if (b0.state !== 4'd8 || b0.pc_en !== bp[i] || b0.pcsrc !== 2'b01 || b0.alucontrol !== 3'b110 || b0.instr_done !== 1'b1) begin
                errors++; $display("FAIL branch op %b z %b got state %0d pc_en %b pcsrc %b alu %b done %b exp 8 %b 01 110 1",
                    bo[i], bz[i], b0.state, b0.pc_en, b0.pcsrc, b0.alucontrol, b0.instr_done, bp[i]); end
            nxt();
            @(negedge clk);
            checks++; if (b0.state !== 4'd0) begin errors++; $display("FAIL branch_end got %0d exp 0", b0.state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_bne_disabled();
        do_reset(); op = BNE; mem_ready = 1'b1;
        nxt();
        @(negedge clk);
        checks++; if (b1.state !== 4'd1 || b1.illegal !== 1'b1 || b1.instr_done !== 1'b1) begin
            errors++; $display("FAIL bne_off got state %0d ill %b done %b exp 1 1 1", b1.state, b1.illegal, b1.instr_done); end
        nxt();
        @(negedge clk);
        checks++; if (b1.state !== 4'd0) begin errors++; $display("FAIL bne_off_end got %0d exp 0", b1.state); end
    endtask

    task automatic test_jump_addi_illegal();
        do_reset(); op = JMP; mem_ready = 1'b1;
        nxt(); nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd11 || b0.pc_en !== 1'b1 || b0.pcsrc !== 2'b10 || b0.instr_done !== 1'b1) begin
            errors++; $display("FAIL jump got state %0d pc_en %b pcsrc %b done %b exp 11 1 10 1", b0.state, b0.pc_en, b0.pcsrc, b0.instr_done); end
        do_reset(); op = ADDI;
        nxt(); nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd9 || {b0.alusrca, b0.alusrcb, b0.alucontrol} !== 6'b110010 || b0.regwrite !== 1'b0) begin
            errors++; $display("FAIL addiex got state %0d mux %b rw %b exp 9 110010 0", b0.state, {b0.alusrca, b0.alusrcb, b0.alucontrol}, b0.regwrite); end
        nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd10 || {b0.regdst, b0.memtoreg, b0.regwrite, b0.instr_done} !== 4'b0011) begin
            errors++; $display("FAIL addiwb got state %0d ctl %b exp 10 0011", b0.state, {b0.regdst, b0.memtoreg, b0.regwrite, b0.instr_done}); end
        do_reset(); op = 6'b111111;
        nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd1 || b0.illegal !== 1'b1 || b0.instr_done !== 1'b1) begin
            errors++; $display("FAIL illegal_op got state %0d ill %b done %b exp 1 1 1", b0.state, b0.illegal, b0.instr_done); end
        nxt();
        @(negedge clk);
        checks++; if (b0.state !== 4'd0 || b0.illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_end got state %0d ill %b exp 0 0", b0.state, b0.illegal); end
    endtask

    task automatic test_no_stall();
        do_reset(); op = LW; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (b2.state !== 4'(k)) begin errors++; $display("FAIL nostall_state cyc %0d got %0d exp %0d", k, b2.state, k); end
            nxt();
        end
        @(negedge clk);
        checks++; if (b2.state !== 4'd0 || b0.state !== 4'd0) begin
            errors++; $display("FAIL nostall_end got ns %0d stall %0d exp 0 0", b2.state, b0.state); end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_reset_mid_memwr();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_branch();
        test_bne_disabled();
        test_jump_addi_illegal();
        test_no_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller_unit.md
# multicycle_controller_unit

Control FSM for the multicycle MIPS datapath, replacing the single-cycle combinational controller. Each instruction is sequenced over 3–5 cycles through fetch, decode, execute, memory and writeback states. The block drives the shared-memory, instruction-register, PC-enable and ALU-source controls. Parameters and a memory-ready handshake add optional `bne` support and stalling on slow memory.

## Interface
Parameters:
- `ENABLE_BNE`, 1: decode opcode 000101 (`bne`). When 0, that opcode is illegal.
- `ENABLE_STALL`, 1: honour `mem_ready`. When 0, `mem_ready` is treated as constant 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  opcode field from the instruction register.
- `funct`  in  4  low 4 bits of the funct field.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_en`  out  1  PC register write enable.
- `iord`  out  1  memory address mux select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  data memory write enable.
- `irwrite`  out  1  instruction register write enable.
- `regdst`  out  1  1 = rd, 0 = rt.
- `memtoreg`  out  1  1 = memory data, 0 = ALUOut.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  0 = PC, 1 = register A.
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- `alucontrol`  out  3  ALU operation.
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state, for debug.

## Operation
States, with encodings and the non-default outputs each drives. All outputs not listed are 0.
- FETCH=0
  - outputs: iord=0, alusrca=0, alusrcb=01, alucontrol=010.
  - when `mem_ready`: irwrite=1 and pc_en=1, then go to DECODE.
  - otherwise: stay in FETCH with irwrite=0 and pc_en=0.
- DECODE=1
  - outputs: alusrca=0, alusrcb=11, alucontrol=010.
  - next state by `op`:
    - 100011 (`lw`) or 101011 (`sw`) → MEMADR
    - 000000 → EXEC
    - 000100, or 000101 when ENABLE_BNE=1 → BRANCH
    - 001000 (`addi`) → ADDIEX
    - 000010 (`j`) → JUMP
    - any other opcode → FETCH with illegal=1 and instr_done=1.
- MEMADR=2: alusrca=1, alusrcb=10, alucontrol=010. Next state is MEMRD for `lw`, MEMWR for `sw`.
- MEMRD=3: iord=1. Stays in MEMRD until `mem_ready`, then MEMWB.
- MEMWB=4: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR=5: iord=1, memwrite=1. memwrite is held while `mem_ready`=0; on `mem_ready`, instr_done=1 and next state FETCH.
- EXEC=6: alusrca=1, alusrcb=00, alucontrol decoded from `funct`:
  - 0000 → 010 (add)
  - 0010 → 110 (sub)
  - 0100 → 000 (and)
  - 0101 → 001 (or)
  - 1010 → 111 (slt)
  - any other value → alucontrol=010, illegal=1, next state FETCH with instr_done=1, regwrite never asserted.
  - legal funct: next state ALUWB.
- ALUWB=7: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- BRANCH=8: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, instr_done=1. Next state FETCH.
  - pc_en = `zero` for op 000100 (`beq`).
  - pc_en = `!zero` for op 000101 (`bne`).
- ADDIEX=9: alusrca=1, alusrcb=10, alucontrol=010. Next state ADDIWB.
- ADDIWB=10: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- JUMP=11: pcsrc=10, pc_en=1, instr_done=1. Next state FETCH.
- Unused encodings 12–15 go to FETCH next cycle with all enables 0.

## Timing
- State register is the only storage.
- All outputs are combinational from `state`, `op`, `funct`, `zero` and `mem_ready`. There is no output register.
- Reset: while `rst`=1, state=FETCH and pc_en, irwrite, regwrite, memwrite, instr_done and illegal are forced to 0. Mux selects take their FETCH values.
- Reset asserted mid-instruction (any state) forces FETCH immediately. No partial write completes after `rst` rises.
- First fetch is the cycle after `rst` deasserts.
- Cycle counts with `mem_ready`=1 throughout:
  - 3 cycles: beq, bne, j.
  - 4 cycles: R-type, addi, sw.
  - 5 cycles: lw.
  - 2 cycles: illegal opcode.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Other states ignore `mem_ready`.
- `op` and `funct` must be stable from DECODE until the instruction's last state; the IR is written only in FETCH.

## Test plan
- Reset mid-MEMWR: assert `rst` → memwrite=0 in the same cycle and state=0. Release `rst` → FETCH with irwrite=1 one cycle later (`mem_ready`=1).
- `lw` (op=100011), `mem_ready`=1 → state sequence 0,1,2,3,4. regwrite=1 and memtoreg=1 only in state 4. instr_done pulses once.
- `sw` with `mem_ready` low for 3 cycles in MEMWR → memwrite held 4 cycles, instr_done on the 4th, total 7 cycles.
- R-type, funct=0010 → alucontrol=110 in EXEC, then regdst=1 and regwrite=1 in ALUWB. Repeat with funct=1111 → illegal=1, regwrite never 1.
- Branches:
  - `beq` with zero=1 → pc_en=1, pcsrc=01.
  - `bne` with zero=1 → pc_en=0.
  - ENABLE_BNE=0 with op=000101 → illegal=1, back to FETCH after DECODE.
- `j` → pc_en=1, pcsrc=10 in state 11.
- ENABLE_STALL=0 with `mem_ready`=0 → lw still completes in 5 cycles.
